// File: rtl/regfile_dump_reader_if.sv
// ============================================================================
// regfile_dump_reader_if
// Register-file read port plus the valid/ready word stream of the dump reader.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface regfile_dump_reader_if;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [31:0] out_data;

    modport master (
        output rd_addr,
        input  rd_data,
        output out_valid,
        input  out_ready,
        output out_idx,
        output out_data
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  out_valid,
        output out_ready,
        input  out_idx,
        input  out_data
    );
endinterface

`default_nettype wire

// File: rtl/regfile_dump_reader.sv
// ============================================================================
// regfile_dump_reader
// Walks FIRST_REG..LAST_REG through one register-file read port and streams
// each (index, data) pair on a valid/ready output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int ZERO_X0   = 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               start_i,
    input  wire logic               abort_i,
    regfile_dump_reader_if.master   bus,
    output logic                    busy_o,
    output logic                    done_o
);

    if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_param_check
        $error("regfile_dump_reader: illegal FIRST_REG/LAST_REG");
    end

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic [4:0]  cur_idx_q,   cur_idx_d;
    logic        out_valid_q, out_valid_d;
    logic [4:0]  out_idx_q,   out_idx_d;
    logic [31:0] out_data_q,  out_data_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;

    always_comb begin
        state_d     = state_q;
        cur_idx_d   = cur_idx_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;

        // Abort outranks everything outside IDLE, including a pending handshake.
        if (abort_i && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            cur_idx_d   = FIRST_IDX;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        state_d   = S_READ;
                        cur_idx_d = FIRST_IDX;
                    end
                end
                S_READ: begin
                    out_data_d  = (ZERO_X0 != 0 && cur_idx_q == 5'd0) ? 32'h0 : bus.rd_data;
                    out_idx_d   = cur_idx_q;
                    out_valid_d = 1'b1;
                    state_d     = S_SEND;
                end
                S_SEND: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        if (cur_idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            cur_idx_d = cur_idx_q + 5'd1;
                            state_d   = S_READ;
                        end
                    end
                end
                S_DONE: begin
                    state_d   = S_IDLE;
                    cur_idx_d = FIRST_IDX;
                end
                default: begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    cur_idx_d   = FIRST_IDX;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_idx_q   <= FIRST_IDX;
            out_valid_q <= 1'b0;
            out_idx_q   <= 5'd0;
            out_data_q  <= 32'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_idx_q   <= cur_idx_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.rd_addr   = cur_idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_data  = out_data_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
// ============================================================================
// tb_regfile_dump_reader
// Directed bench for the dump reader: full dump, back-pressure, single-word
// range, snapshot write, abort and asynchronous reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_dump_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, abort0 = 1'b0, busy0, done0;
    logic start1 = 1'b0, abort1 = 1'b0, busy1, done1;
    logic [31:0] rf [32];

    int n_checks = 0;
    int n_fail   = 0;

    regfile_dump_reader_if bus0 ();
    regfile_dump_reader_if bus1 ();

    assign bus0.rd_data = rf[bus0.rd_addr];
    assign bus1.rd_data = rf[bus1.rd_addr];

    regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .ZERO_X0(1)) u_dut0 (
        .clk(clk), .rst(rst), .start_i(start0), .abort_i(abort0),
        .bus(bus0.master), .busy_o(busy0), .done_o(done0)
    );

    regfile_dump_reader #(.FIRST_REG(3), .LAST_REG(3), .ZERO_X0(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .abort_i(abort1),
        .bus(bus1.master), .busy_o(busy1), .done_o(done1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int k);
        return (k == 0) ? 32'h0 : rf[k];
    endfunction

    initial begin
        int nexp, firstv, dcnt, dcyc, cyc;
        logic stall;
        logic [4:0]  p_idx;
        logic [31:0] p_data;

        for (int i = 0; i < 32; i++) rf[i] = 32'hC0DE0000 | 32'(i);
        rf[0]  = 32'h12345678;
        rf[1]  = 32'h11111111;
        rf[3]  = 32'hDEADBEEF;
        rf[31] = 32'hFFFF0001;
        bus0.out_ready = 1'b1;
        bus1.out_ready = 1'b1;

        // Reset state
        step();
        chk("rst_valid", 32'(bus0.out_valid), 32'h0);
        chk("rst_idx",   32'(bus0.out_idx),   32'h0);
        chk("rst_data",  bus0.out_data,       32'h0);
        chk("rst_busy",  32'(busy0),          32'h0);
        chk("rst_done",  32'(done0),          32'h0);
        chk("rst_addr",  32'(bus1.rd_addr),   32'd3);
        rst = 1'b0;
        step();

        // start together with abort in IDLE: stays idle
        start0 = 1'b1; abort0 = 1'b1;
        step();
        start0 = 1'b0; abort0 = 1'b0;
        chk("sa_busy", 32'(busy0), 32'h0);
        step();
        chk("sa_busy2", 32'(busy0), 32'h0);

        // Full dump with out_ready held high
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        nexp = 0; firstv = -1; dcnt = 0; dcyc = -1;
        for (cyc = 1; cyc <= 80; cyc++) begin
            if (bus0.out_valid) begin
                if (firstv < 0) firstv = cyc;
                chk("full_idx",  32'(bus0.out_idx), 32'(nexp));
                chk("full_data", bus0.out_data,     exp_word(nexp));
                nexp++;
            end
            if (done0) begin dcnt++; dcyc = cyc; end
            step();
        end
        chk("full_count", 32'(nexp),   32'd32);
        chk("full_first", 32'(firstv), 32'd2);
        chk("full_dcnt",  32'(dcnt),   32'd1);
        chk("full_dcyc",  32'(dcyc),   32'd65);
        chk("full_busy",  32'(busy0),  32'h0);

        // Random back-pressure, snapshot write of x5, ignored second start
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        nexp = 0; dcnt = 0; stall = 1'b0; p_idx = '0; p_data = '0;
        for (cyc = 1; cyc <= 400 && dcnt == 0; cyc++) begin
            start0 = (cyc == 10);
            if (stall) begin
                chk("hold_valid", 32'(bus0.out_valid), 32'h1);
                chk("hold_idx",   32'(bus0.out_idx),   32'(p_idx));
                chk("hold_data",  bus0.out_data,       p_data);
            end
            bus0.out_ready = 1'($urandom_range(0, 1));
            stall = 1'b0;
            if (bus0.out_valid) begin
                if (bus0.out_idx == 5'd2) rf[5] = 32'hA5A5A5A5;
                if (bus0.out_ready) begin
                    chk("bp_idx",  32'(bus0.out_idx), 32'(nexp));
                    chk("bp_data", bus0.out_data,     exp_word(nexp));
                    nexp++;
                end else begin
                    stall  = 1'b1;
                    p_idx  = bus0.out_idx;
                    p_data = bus0.out_data;
                end
            end
            if (done0) dcnt++;
            step();
        end
        start0 = 1'b0;
        chk("bp_count", 32'(nexp),  32'd32);
        chk("bp_done",  32'(dcnt),  32'd1);
        chk("bp_x5",    rf[5],      32'hA5A5A5A5);
        bus0.out_ready = 1'b1;
        step();

        // Single-word range FIRST_REG == LAST_REG == 3
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        nexp = 0; dcnt = 0;
        for (cyc = 1; cyc <= 10; cyc++) begin
            if (bus1.out_valid) begin
                chk("one_idx",  32'(bus1.out_idx), 32'd3);
                chk("one_data", bus1.out_data,     32'hDEADBEEF);
                nexp++;
            end
            if (done1) dcnt++;
            step();
        end
        chk("one_count", 32'(nexp), 32'd1);
        chk("one_done",  32'(dcnt), 32'd1);

        // Abort while idx 7 is in SEND
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (cyc = 0; cyc < 40 && !(bus0.out_valid && bus0.out_idx == 5'd7); cyc++) step();
        chk("ab_reach", 32'(bus0.out_idx), 32'd7);
        bus0.out_ready = 1'b0;
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        chk("ab_valid", 32'(bus0.out_valid), 32'h0);
        chk("ab_busy",  32'(busy0),          32'h0);
        dcnt = 0;
        for (cyc = 0; cyc < 5; cyc++) begin
            if (done0 || bus0.out_valid) dcnt++;
            step();
        end
        chk("ab_quiet", 32'(dcnt), 32'h0);
        bus0.out_ready = 1'b1;

        // Asynchronous reset mid-dump at idx 12
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (cyc = 0; cyc < 60 && !(bus0.out_valid && bus0.out_idx == 5'd12); cyc++) step();
        chk("rs_reach", 32'(bus0.out_idx), 32'd12);
        #2 rst = 1'b1;
        #1;
        chk("rs_valid", 32'(bus0.out_valid), 32'h0);
        chk("rs_idx",   32'(bus0.out_idx),   32'h0);
        chk("rs_data",  bus0.out_data,       32'h0);
        chk("rs_busy",  32'(busy0),          32'h0);
        chk("rs_done",  32'(done0),          32'h0);
        chk("rs_addr",  32'(bus0.rd_addr),   32'h0);
        step();
        rst = 1'b0;
        step();

        // Restart after reset begins at idx 0
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        nexp = 0;
        for (cyc = 0; cyc < 8; cyc++) begin
            if (bus0.out_valid) begin
                chk("re_idx",  32'(bus0.out_idx), 32'(nexp));
                chk("re_data", bus0.out_data,     exp_word(nexp));
                nexp++;
            end
            step();
        end
        chk("re_count", 32'(nexp), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
